// File: rtl/forth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : forth_ctrl_pkg
// Brief  : Shared Forth-core control encodings (Y-mux selects, MD/SR ops, FSM)
// Rev    : 1.0  initial release
// ============================================================================
package forth_ctrl_pkg;

  localparam logic [2:0] Y_N     = 3'b000;
  localparam logic [2:0] Y_NC    = 3'b001;
  localparam logic [2:0] Y_MD    = 3'b010;
  localparam logic [2:0] Y_SR    = 3'b011;
  localparam logic [2:0] Y_GBUS  = 3'b100;
  localparam logic [2:0] Y_R     = 3'b101;
  localparam logic [2:0] Y_PC    = 3'b110;
  localparam logic [2:0] Y_INDEX = 3'b111;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_INIT   = 2'b01,
    ST_STEP   = 2'b10,
    ST_FINISH = 2'b11
  } md_state_t;

  // Square root iterates on the SR accumulator; multiply and divide share MD.
  function automatic logic [2:0] step_sel(input logic [1:0] op);
    return (op == OP_SQRT) ? Y_SR : Y_MD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_counter.sv
`default_nettype none
// ============================================================================
// Module : step_counter
// Brief  : Iteration counter with clear, enable and terminal-count flag
// Rev    : 1.0  initial release
// ============================================================================
module step_counter #(
  parameter int STEPS = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/md_sr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : md_sr_sequencer
// Brief  : Multi-cycle multiply/divide/sqrt sequencer driving the Y-mux select
// Rev    : 1.0  initial release
// ============================================================================
module md_sr_sequencer
  import forth_ctrl_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  output logic [2:0]       select_y,
  output logic             load_en,
  output logic             step_en,
  output logic             wb_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  md_state_t  r_state;
  md_state_t  w_next;
  logic [1:0] r_op;
  logic       r_err;
  logic       w_tc;
  logic       w_accept;
  logic       w_reject;

  assign w_accept = (r_state == ST_IDLE) && start && !abort && (op != OP_ILL);
  assign w_reject = (r_state == ST_IDLE) && start && !abort && (op == OP_ILL);

  // Counter only runs while iterating; any exit from STEP returns it to zero.
  step_counter #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_next != ST_STEP),
    .en    (r_state == ST_STEP),
    .cnt   (step_cnt),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_reject;
      if (w_accept) begin
        r_op <= op;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    select_y = Y_N;
    load_en  = 1'b0;
    step_en  = 1'b0;
    wb_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_INIT;
        end
      end
      ST_INIT: begin
        load_en = 1'b1;
        busy    = 1'b1;
        w_next  = abort ? ST_IDLE : ST_STEP;
      end
      ST_STEP: begin
        step_en  = 1'b1;
        busy     = 1'b1;
        select_y = step_sel(r_op);
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_tc) begin
          w_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // Divide needs the carry-corrected remainder path on write-back.
        wb_en    = 1'b1;
        done     = 1'b1;
        busy     = 1'b1;
        select_y = (r_op == OP_DIV) ? Y_NC : Y_N;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_md_sr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_md_sr_sequencer
// Brief  : Scoreboard bench for md_sr_sequencer against an operation-timeline model
// Rev    : 1.0  initial release
// ============================================================================
module tb_md_sr_sequencer;

  localparam int STEPS = 16;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [2:0]       sel;
    logic             ld;
    logic             st;
    logic             wb;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic             err;
  } obs_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic             abort;
  logic [2:0]       select_y;
  logic             load_en;
  logic             step_en;
  logic             wb_en;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;
  logic             done;
  logic             err;

  int tests;
  int fails;

  obs_t got;
  obs_t expq[$];

  // Reference model state: position within an operation's timeline.
  bit         m_act;
  int         m_k;
  logic [1:0] m_op;
  bit         m_err;

  md_sr_sequencer #(
    .STEPS (STEPS),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .abort    (abort),
    .select_y (select_y),
    .load_en  (load_en),
    .step_en  (step_en),
    .wb_en    (wb_en),
    .step_cnt (step_cnt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  assign got = {select_y, load_en, step_en, wb_en, step_cnt, busy, done, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline: k=0 load, k=1..STEPS iterate, k=STEPS+1 write back.
  function automatic obs_t expect_out(bit act, int k, logic [1:0] o, bit e);
    obs_t x;
    x     = '0;
    x.err = e;
    if (act) begin
      x.busy = 1'b1;
      if (k == 0) begin
        x.ld = 1'b1;
      end else if (k <= STEPS) begin
        x.st  = 1'b1;
        x.cnt = CNT_W'(k - 1);
        x.sel = (o == 2'b10) ? 3'b011 : 3'b010;
      end else begin
        x.wb   = 1'b1;
        x.done = 1'b1;
        x.sel  = (o == 2'b01) ? 3'b001 : 3'b000;
      end
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_k   = 0;
      m_op  = 2'b00;
      m_err = 1'b0;
      expq.delete();
    end else begin
      if (m_act) begin
        m_err = 1'b0;
        if (abort || m_k == STEPS + 1) m_act = 1'b0;
        else m_k = m_k + 1;
      end else begin
        m_err = start && !abort && (op == 2'b11);
        if (start && !abort && op != 2'b11) begin
          m_act = 1'b1;
          m_k   = 0;
          m_op  = op;
        end
      end
      expq.push_back(expect_out(m_act, m_k, m_op, m_err));
    end
  end

  always @(negedge clk) begin
    obs_t e;
    if (rst_n && expq.size() > 0) begin
      e = expq.pop_front();
      tests = tests + 1;
      if (got !== e) begin
        fails = fails + 1;
        $display("FAIL seq_out t=%0t got sel=%b ld=%b st=%b wb=%b cnt=%0d busy=%b done=%b err=%b exp sel=%b ld=%b st=%b wb=%b cnt=%0d busy=%b done=%b err=%b",
                 $time, got.sel, got.ld, got.st, got.wb, got.cnt, got.busy, got.done, got.err,
                 e.sel, e.ld, e.st, e.wb, e.cnt, e.busy, e.done, e.err);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    tests = tests + 1;
    if (got !== obs_t'(0)) begin
      fails = fails + 1;
      $display("FAIL %s got=%h exp=%h", name, got, obs_t'(0));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] o);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    abort = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_step(input int v);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (step_en === 1'b1 && step_cnt === CNT_W'(v)) seen = 1'b1;
    end
    if (!seen) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL wait_step got=timeout required step_cnt=%0d", v);
    end
  endtask

  task automatic wait_finish();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (wb_en === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL wait_finish got=timeout required wb_en=1");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;

    // Directed: each op uninterrupted, then illegal op.
    pulse(2'b00); idle(20);
    pulse(2'b10); idle(20);
    pulse(2'b01); idle(20);
    pulse(2'b11); idle(4);

    // Abort with start in the same cycle: no err, no operation.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    idle(3);

    // Abort at step 7.
    pulse(2'b00);
    wait_step(7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idle(4);

    // Abort during the write-back cycle.
    pulse(2'b01);
    wait_finish();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idle(4);

    // Start while busy is ignored; start in FINISH also ignored.
    pulse(2'b10);
    wait_step(3);
    start = 1'b1; op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_step(10);
    start = 1'b1; op = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    wait_finish();
    start = 1'b1; op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    idle(4);

    // Back-to-back: restart from the first IDLE cycle.
    pulse(2'b00);
    wait_finish();
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    idle(22);

    // Asynchronous reset in the middle of an operation.
    pulse(2'b01);
    wait_step(5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset_midop");
    repeat (2) @(negedge clk);
    check_reset_vals("async_reset_hold");
    rst_n = 1'b1;
    pulse(2'b00);
    idle(22);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start = ($urandom % 4) == 0;
      op    = 2'($urandom % 4);
      abort = ($urandom % 24) == 0;
    end
    start = 1'b0;
    abort = 1'b0;
    idle(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
